adc_cap_sequencer: RTL and testbench



---
 rtl/adc_cap_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_adc_cap_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cap_sequencer.sv
// ---------------------------------------------------------------------------
// adc_cap_sequencer
//
// Purpose: arbitrates capture requests from NUM_REQ requesters (round-robin)
// and sequences a bank of NUM_CAP ADC capture-to-BRAM engines. For each grant
// it strobes the selected engines, waits for them to leave idle and return
// to idle, flags engines that miss either deadline, and acknowledges the
// requester.
//
// Ports:
//   aclk, aresetn    clock shared with the engines; async active-low reset
//   req_i            per-requester request level
//   cap_mask_i       engine select, slice r = [r*NUM_CAP +: NUM_CAP]
//   req_ack_o        one-cycle ack pulse to the granted requester
//   capture_o        capture strobes to the engines
//   done_i           engine idle flags (1 = idle)
//   busy_o           sequencer is not in IDLE
//   grant_id_o       requester currently or last granted
//   capture_count_o  successful captures (wraps)
//   timeout_o        sticky timeout flag
//   err_mask_o       sticky per-engine failure flags
//   clear_i          synchronous clear of timeout_o / err_mask_o
//
// Handshake: a requester raises req_i[r] and holds it until it sees
// req_ack_o[r] high for one cycle; it must drop (or re-arm) the request in
// that same cycle. The ack appears the cycle after COMPLETE, while the FSM
// is already back in IDLE, so a request still high at the next edge is
// treated as a new request.
// ---------------------------------------------------------------------------
module adc_cap_sequencer #(
  parameter int NUM_CAP        = 4,
  parameter int NUM_REQ        = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int START_WAIT     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*NUM_CAP-1:0] cap_mask_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [NUM_CAP-1:0]         capture_o,
  input  logic [NUM_CAP-1:0]         done_i,
  output logic                       busy_o,
  output logic [GW-1:0]              grant_id_o,
  output logic [31:0]                capture_count_o,
  output logic                       timeout_o,
  output logic [NUM_CAP-1:0]         err_mask_o,
  input  logic                       clear_i
);

  // One counter serves the strobe width, start wait and done timeout.
  localparam int CMAX = (TIMEOUT_CYCLES > START_WAIT + 1) ? TIMEOUT_CYCLES : START_WAIT + 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = GW + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_COMPLETE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_CAP-1:0]   sel_q, sel_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 ok_q, ok_d;
  logic [NUM_CAP-1:0]   capture_q, capture_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [31:0]          count_q, count_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_CAP-1:0]   err_q, err_d;

  // Round-robin pick: first requester at or after ptr_q, wrapping.
  logic                 found;
  logic [GW-1:0]        gidx;
  logic [AW-1:0]        sum;
  logic [NUM_CAP-1:0]   mask_new;
  logic [NUM_CAP-1:0]   sel_done;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + AW'(i);
      if (sum >= AW'(NUM_REQ)) sum = sum - AW'(NUM_REQ);
      if (!found && req_i[sum[GW-1:0]]) begin
        found = 1'b1;
        gidx  = sum[GW-1:0];
      end
    end
    mask_new = cap_mask_i[int'(gidx)*NUM_CAP +: NUM_CAP];
  end

  // Only selected engines are looked at.
  assign sel_done = done_i & sel_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ok_d      = ok_q;
    capture_d = '0;
    ack_d     = '0;
    count_d   = count_q;
    // Clear first, then any new error below overrides it.
    timeout_d = clear_i ? 1'b0 : timeout_q;
    err_d     = clear_i ? '0   : err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) begin
          grant_d = gidx;
          sel_d   = mask_new;
          ptr_d   = (gidx == GW'(NUM_REQ - 1)) ? '0 : gidx + GW'(1);
          ok_d    = 1'b0;
          state_d = (mask_new == '0) ? S_COMPLETE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        capture_d = sel_q;
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // The count starts when the strobe register drops, so the deadline
        // lands START_WAIT clocks after the strobe ends.
        if (sel_done == '0) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_WAIT)) begin
          timeout_d = 1'b1;
          err_d     = err_d | sel_done;
          ok_d      = 1'b0;
          state_d   = S_COMPLETE;
        end
      end
      S_WAIT_DONE: begin
        if (sel_done == sel_q) begin
          ok_d    = 1'b1;
          state_d = S_COMPLETE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          err_d     = err_d | (sel_q & ~done_i);
          ok_d      = 1'b0;
          state_d   = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        ack_d[grant_q] = 1'b1;
        if (ok_q && (sel_q != '0)) count_d = count_q + 32'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      ok_q      <= 1'b0;
      capture_q <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ok_q      <= ok_d;
      capture_q <= capture_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign req_ack_o       = ack_q;
  assign capture_o       = capture_q;
  assign busy_o          = busy_q;
  assign grant_id_o      = grant_q;
  assign capture_count_o = count_q;
  assign timeout_o       = timeout_q;
  assign err_mask_o      = err_q;

endmodule

// File: tb/tb_adc_cap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_cap_sequencer: directed self-checking bench for adc_cap_sequencer.
// A small engine model drives done_i: after a strobe ends it drops done
// start_dly clocks later and raises it busy_len clocks after that.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_adc_cap_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [2:0]  req_i = '0;
  logic [11:0] cap_mask_i = '0;
  logic [3:0]  done_i;
  logic        clear_i = 1'b0;
  logic [2:0]  req_ack_o;
  logic [3:0]  capture_o;
  logic        busy_o;
  logic [1:0]  grant_id_o;
  logic [31:0] capture_count_o;
  logic        timeout_o;
  logic [3:0]  err_mask_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_count = '0;

  // engine model
  int          start_dly = 3;
  int          busy_len = 4;
  logic [3:0]  stuck_hi = '0;
  logic [3:0]  force_lo = '0;
  logic [3:0]  done_r = '1;
  logic [3:0]  arm = '0;
  int          ecnt [4];

  assign done_i = (done_r | stuck_hi) & ~force_lo;

  adc_cap_sequencer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .req_i           (req_i),
    .cap_mask_i      (cap_mask_i),
    .req_ack_o       (req_ack_o),
    .capture_o       (capture_o),
    .done_i          (done_i),
    .busy_o          (busy_o),
    .grant_id_o      (grant_id_o),
    .capture_count_o (capture_count_o),
    .timeout_o       (timeout_o),
    .err_mask_o      (err_mask_o),
    .clear_i         (clear_i)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      arm    = '0;
      done_r = '1;
    end else begin
      for (int e = 0; e < 4; e++) begin
        if (capture_o[e]) begin
          arm[e]  = 1'b1;
          ecnt[e] = 0;
        end else if (arm[e]) begin
          ecnt[e]++;
          if (ecnt[e] == start_dly) done_r[e] = 1'b0;
          if (ecnt[e] == start_dly + busy_len) begin
            done_r[e] = 1'b1;
            arm[e]    = 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (capture_o !== 4'b0) begin failures++; $display("FAIL reset_capture: got %b expected 0000", capture_o); end
    checks++; if (req_ack_o !== 3'b0) begin failures++; $display("FAIL reset_ack: got %b expected 000", req_ack_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (grant_id_o !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id_o); end
    checks++; if (capture_count_o !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", capture_count_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    checks++; if (err_mask_o !== 4'b0) begin failures++; $display("FAIL reset_err: got %b expected 0000", err_mask_o); end
    aresetn = 1'b1;
    @(negedge aclk);
    exp_count = '0;
  endtask

  task automatic test_fairness();
    int         exp_id [6] = '{0, 1, 2, 0, 1, 2};
    int         n = 0;
    logic [2:0] prev_ack = '0;
    logic [2:0] exp_ack;
    logic       restore = 1'b0;
    cap_mask_i = {4'b0100, 4'b0010, 4'b0001};
    start_dly  = 1;
    busy_len   = 3;
    req_i      = 3'b111;
    for (int c = 0; c < 600 && n < 6; c++) begin
      @(negedge aclk);
      if (restore) begin req_i = 3'b111; restore = 1'b0; end
      if (prev_ack != 3'b0) begin
        checks++; if (req_ack_o !== 3'b0) begin failures++; $display("FAIL fair_pulse: got %b expected 000", req_ack_o); end
      end
      if (req_ack_o != 3'b0) begin
        exp_ack = '0;
        exp_ack[exp_id[n]] = 1'b1;
        checks++; if (req_ack_o !== exp_ack || grant_id_o !== 2'(exp_id[n])) begin
          failures++; $display("FAIL fair_order%0d: got ack=%b id=%0d expected ack=%b id=%0d", n, req_ack_o, grant_id_o, exp_ack, exp_id[n]);
        end
        req_i = req_i & ~req_ack_o;
        restore = 1'b1;
        n++;
        if (n == 6) req_i = 3'b000;
      end
      prev_ack = req_ack_o;
    end
    checks++; if (n != 6) begin failures++; $display("FAIL fair_timeout: got %0d acks expected 6", n); end
    @(negedge aclk);
    checks++; if (req_ack_o !== 3'b0) begin failures++; $display("FAIL fair_last_pulse: got %b expected 000", req_ack_o); end
    exp_count += 6;
    checks++; if (capture_count_o !== exp_count) begin failures++; $display("FAIL fair_count: got %0d expected %0d", capture_count_o, exp_count); end
  endtask

  task automatic test_single();
    int         cap_first = -1;
    int         cap_cnt = 0;
    int         ack_cnt = 0;
    int         ack_c = -1;
    logic [2:0] ack_v = '0;
    cap_mask_i = {4'b0000, 4'b0000, 4'b0101};
    force_lo   = 4'b0010;  // unselected engine held busy; must be ignored
    start_dly  = 3;
    busy_len   = 2048;
    @(negedge aclk);
    req_i = 3'b001;
    for (int c = 1; c < 2200; c++) begin
      @(negedge aclk);
      if (c == 1) cap_mask_i[3:0] = 4'b1111;  // must not affect this grant
      if (capture_o != 4'b0) begin
        if (cap_first < 0) cap_first = c;
        cap_cnt++;
        checks++; if (capture_o !== 4'b0101) begin failures++; $display("FAIL single_cap_val: got %b expected 0101", capture_o); end
      end
      if (req_ack_o != 3'b0) begin
        ack_cnt++;
        if (ack_c < 0) begin ack_c = c; ack_v = req_ack_o; end
        req_i = 3'b000;
      end
      if (ack_c > 0 && c == ack_c + 3) break;
    end
    exp_count += 1;
    checks++; if (cap_first !== 2) begin failures++; $display("FAIL single_cap_latency: got %0d expected 2", cap_first); end
    checks++; if (cap_cnt !== 4) begin failures++; $display("FAIL single_cap_width: got %0d expected 4", cap_cnt); end
    checks++; if (ack_cnt !== 1) begin failures++; $display("FAIL single_ack_count: got %0d expected 1", ack_cnt); end
    checks++; if (ack_c !== 2058) begin failures++; $display("FAIL single_ack_time: got %0d expected 2058", ack_c); end
    checks++; if (ack_v !== 3'b001) begin failures++; $display("FAIL single_ack_val: got %b expected 001", ack_v); end
    checks++; if (capture_count_o !== exp_count) begin failures++; $display("FAIL single_count: got %0d expected %0d", capture_count_o, exp_count); end
    checks++; if (timeout_o !== 1'b0 || err_mask_o !== 4'b0) begin failures++; $display("FAIL single_flags: got to=%b err=%b expected 0 0000", timeout_o, err_mask_o); end
    force_lo = '0;
  endtask

  task automatic test_start_fail();
    int         t_rise = -1;
    logic [3:0] err_at = '0;
    int         ack_c = -1;
    logic [2:0] ack_v = '0;
    cap_mask_i = {4'b0000, 4'b0010, 4'b0000};
    stuck_hi   = 4'b0010;
    start_dly  = 3;
    busy_len   = 4;
    @(negedge aclk);
    req_i = 3'b010;
    for (int c = 1; c < 100; c++) begin
      @(negedge aclk);
      if (timeout_o && t_rise < 0) begin t_rise = c; err_at = err_mask_o; end
      if (req_ack_o != 3'b0 && ack_c < 0) begin ack_c = c; ack_v = req_ack_o; req_i = 3'b000; end
      if (ack_c > 0) break;
    end
    checks++; if (t_rise !== 22) begin failures++; $display("FAIL start_to_time: got %0d expected 22", t_rise); end
    checks++; if (err_at !== 4'b0010) begin failures++; $display("FAIL start_err: got %b expected 0010", err_at); end
    checks++; if (ack_c !== 23 || ack_v !== 3'b010) begin failures++; $display("FAIL start_ack: got t=%0d ack=%b expected t=23 ack=010", ack_c, ack_v); end
    checks++; if (capture_count_o !== exp_count) begin failures++; $display("FAIL start_count: got %0d expected %0d", capture_count_o, exp_count); end
    stuck_hi = '0;
    clear_i  = 1'b1;
    @(negedge aclk);
    clear_i  = 1'b0;
    checks++; if (timeout_o !== 1'b0 || err_mask_o !== 4'b0) begin failures++; $display("FAIL start_clear: got to=%b err=%b expected 0 0000", timeout_o, err_mask_o); end
  endtask

  task automatic test_done_timeout();
    int         ack_c = -1;
    logic [2:0] ack_v = '0;
    cap_mask_i = {4'b1000, 4'b0000, 4'b0000};
    start_dly  = 3;
    busy_len   = 5000;
    @(negedge aclk);
    req_i = 3'b100;
    for (int c = 1; c < 5300; c++) begin
      @(negedge aclk);
      if (c == 4104) begin
        checks++; if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin failures++; $display("FAIL done_pre: got busy=%b to=%b expected 1 0", busy_o, timeout_o); end
        clear_i = 1'b1;  // same edge as the new error: set must win
      end
      if (c == 4105) begin
        clear_i = 1'b0;
        checks++; if (timeout_o !== 1'b1 || err_mask_o !== 4'b1000) begin failures++; $display("FAIL done_set_wins: got to=%b err=%b expected 1 1000", timeout_o, err_mask_o); end
      end
      if (req_ack_o != 3'b0 && ack_c < 0) begin ack_c = c; ack_v = req_ack_o; req_i = 3'b000; end
      if (ack_c > 0 && done_i == 4'b1111) break;
    end
    checks++; if (ack_c !== 4106 || ack_v !== 3'b100) begin failures++; $display("FAIL done_ack: got t=%0d ack=%b expected t=4106 ack=100", ack_c, ack_v); end
    checks++; if (capture_count_o !== exp_count) begin failures++; $display("FAIL done_count: got %0d expected %0d", capture_count_o, exp_count); end
    checks++; if (done_i !== 4'b1111) begin failures++; $display("FAIL done_engine_idle: got %b expected 1111", done_i); end
  endtask

  task automatic test_zero_mask();
    int         ack_c = -1;
    logic [2:0] ack_v = '0;
    int         cap_seen = 0;
    cap_mask_i = '0;
    @(negedge aclk);
    req_i = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL zero_busy: got %b expected 1", busy_o); end
      end
      if (capture_o != 4'b0) cap_seen++;
      if (req_ack_o != 3'b0 && ack_c < 0) begin ack_c = c; ack_v = req_ack_o; req_i = 3'b000; end
    end
    checks++; if (ack_c !== 2 || ack_v !== 3'b001) begin failures++; $display("FAIL zero_ack: got t=%0d ack=%b expected t=2 ack=001", ack_c, ack_v); end
    checks++; if (cap_seen !== 0) begin failures++; $display("FAIL zero_capture: got %0d strobe cycles expected 0", cap_seen); end
    checks++; if (capture_count_o !== exp_count) begin failures++; $display("FAIL zero_count: got %0d expected %0d", capture_count_o, exp_count); end
  endtask

  task automatic test_async_reset();
    int         ack_c = -1;
    logic [2:0] ack_v = '0;
    logic [1:0] id_v = '0;
    int         ack_cnt = 0;
    cap_mask_i = {4'b0000, 4'b0010, 4'b0000};
    start_dly  = 1;
    busy_len   = 3;
    @(negedge aclk);
    req_i = 3'b010;
    repeat (3) @(negedge aclk);
    checks++; if (capture_o !== 4'b0010) begin failures++; $display("FAIL arst_pre_cap: got %b expected 0010", capture_o); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (capture_o !== 4'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL arst_immediate: got cap=%b busy=%b expected 0000 0", capture_o, busy_o); end
    @(negedge aclk);
    req_i = 3'b000;
    @(negedge aclk);
    checks++; if (req_ack_o !== 3'b0) begin failures++; $display("FAIL arst_no_ack: got %b expected 000", req_ack_o); end
    aresetn   = 1'b1;
    exp_count = '0;
    @(negedge aclk);
    cap_mask_i = {4'b0100, 4'b0010, 4'b0001};
    req_i = 3'b111;
    for (int c = 1; c < 60; c++) begin
      @(negedge aclk);
      if (req_ack_o != 3'b0) begin
        ack_cnt++;
        if (ack_c < 0) begin ack_c = c; ack_v = req_ack_o; id_v = grant_id_o; end
        req_i = 3'b000;
      end
    end
    exp_count += 1;
    checks++; if (ack_c !== 11 || ack_v !== 3'b001 || id_v !== 2'd0) begin failures++; $display("FAIL arst_fresh_ack: got t=%0d ack=%b id=%0d expected t=11 ack=001 id=0", ack_c, ack_v, id_v); end
    checks++; if (ack_cnt !== 1) begin failures++; $display("FAIL arst_ack_count: got %0d expected 1", ack_cnt); end
    checks++; if (capture_count_o !== exp_count) begin failures++; $display("FAIL arst_count: got %0d expected %0d", capture_count_o, exp_count); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_start_fail();
    test_done_timeout();
    test_zero_mask();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
